vpu_lane_engine: RTL and testbench

Parametrised successor to the single-request vector unit. It executes one vector instruction at a time over NUM_LANES parallel lanes and takes ceil(vl/NUM_LANES) beats. It adds per-element masking, signed saturation, element-wise signed MIN/MAX, and multi-beat reductions. It sits between the vector issue logic and the vector register writeback, with full valid/ready backpressure on both sides.

---
 rtl/vpu_lane_engine.sv | 200 ++++++++++++++++++++
 tb/tb_vpu_lane_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_lane_engine.sv
// Vector lane engine: one vector instruction at a time, NUM_LANES elements per EXEC beat,
// with masking, signed saturation, MIN/MAX and multi-beat reductions.

module vpu_lane #(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op_i,
    input  logic              sat_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o
);
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] sum, diff, prod;
    logic              ovf_add, ovf_sub;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign prod = a_i * b_i;
    // Overflow only when the result sign disagrees with what the operand signs allow.
    assign ovf_add = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
    assign ovf_sub = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);

    always_comb begin
        res_o = '0;
        case (op_i)
            4'd0: res_o = (sat_i && ovf_add) ? (a_i[DATA_W-1] ? SMIN : SMAX) : sum;
            4'd1: res_o = (sat_i && ovf_sub) ? (a_i[DATA_W-1] ? SMIN : SMAX) : diff;
            4'd2: res_o = prod;
            4'd3: res_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
            4'd4: res_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
            default: res_o = '0;
        endcase
    end
endmodule

module vpu_lane_engine #(
    parameter int DATA_W    = 32,
    parameter int MAX_VL    = 8,
    parameter int NUM_LANES = 4,
    parameter int VL_W      = $clog2(MAX_VL+1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [3:0]               req_op_i,
    input  logic                     req_sat_i,
    input  logic [VL_W-1:0]          req_vl_i,
    input  logic [4:0]               req_rd_i,
    input  logic [MAX_VL-1:0]        req_mask_i,
    input  logic [MAX_VL*DATA_W-1:0] req_op1_i,
    input  logic [MAX_VL*DATA_W-1:0] req_op2_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [4:0]               rsp_rd_o,
    output logic [MAX_VL*DATA_W-1:0] rsp_result_o,
    output logic                     rsp_error_o,
    output logic                     busy_o
);
    localparam int NUM_BEATS = MAX_VL / NUM_LANES;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [3:0]        op;
        logic              sat;
        logic [VL_W-1:0]   vl;
        logic [4:0]        rd;
        logic [MAX_VL-1:0] mask;
    } ctrl_t;

    state_t                           state_q, state_d;
    ctrl_t                            ctrl_q, ctrl_d;
    logic [MAX_VL-1:0][DATA_W-1:0]    op1_q, op1_d, op2_q, op2_d, result_q, result_d;
    logic [BEAT_W-1:0]                beat_q, beat_d, last_beat_q, last_beat_d;
    logic [DATA_W-1:0]                acc_q, acc_d;
    logic                             seen_q, seen_d, err_q, err_d;

    logic [NUM_LANES-1:0][DATA_W-1:0] lane_a, lane_b, lane_res;
    logic [MAX_VL-1:0]                in_vl;
    logic                             is_red, req_err;

    assign is_red  = (ctrl_q.op == 4'd5) || (ctrl_q.op == 4'd6) || (ctrl_q.op == 4'd7);
    assign req_err = (req_op_i > 4'd7) || (int'(req_vl_i) > MAX_VL);

    // Route the current beat's elements onto the lane array with static indices only.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < MAX_VL; i++) begin
            in_vl[i] = (i < int'(ctrl_q.vl));
            if (i / NUM_LANES == int'(beat_q)) begin
                lane_a[i % NUM_LANES] = op1_q[i];
                lane_b[i % NUM_LANES] = op2_q[i];
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vpu_lane #(.DATA_W(DATA_W)) u_lane (
            .op_i  (ctrl_q.op),
            .sat_i (ctrl_q.sat),
            .a_i   (lane_a[l]),
            .b_i   (lane_b[l]),
            .res_o (lane_res[l])
        );
    end

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        result_d    = result_q;
        beat_d      = beat_q;
        last_beat_d = last_beat_q;
        acc_d       = acc_q;
        seen_d      = seen_q;
        err_d       = err_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                ctrl_d      = '{op: req_op_i, sat: req_sat_i, vl: req_vl_i, rd: req_rd_i, mask: req_mask_i};
                op1_d       = req_op1_i;
                op2_d       = req_op2_i;
                result_d    = '0;
                beat_d      = '0;
                last_beat_d = BEAT_W'((int'(req_vl_i) - 1) / NUM_LANES);
                acc_d       = '0;
                seen_d      = 1'b0;
                err_d       = req_err;
                state_d     = (req_err || req_vl_i == '0) ? RESP : EXEC;
            end
            EXEC: begin
                for (int i = 0; i < MAX_VL; i++) begin
                    if (i / NUM_LANES == int'(beat_q) && in_vl[i]) begin
                        if (!is_red) begin
                            result_d[i] = ctrl_q.mask[i] ? lane_res[i % NUM_LANES] : op1_q[i];
                        end else if (ctrl_q.mask[i]) begin
                            if (ctrl_q.op == 4'd5)
                                acc_d = acc_d + op1_q[i];
                            else if (!seen_d ||
                                     (ctrl_q.op == 4'd6 && $signed(op1_q[i]) < $signed(acc_d)) ||
                                     (ctrl_q.op == 4'd7 && $signed(op1_q[i]) > $signed(acc_d)))
                                acc_d = op1_q[i];
                            seen_d = 1'b1;
                        end
                    end
                end
                if (beat_q == last_beat_q) begin
                    state_d = RESP;
                    if (is_red) begin
                        result_d    = '0;
                        result_d[0] = acc_d;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            acc_q       <= '0;
            seen_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            result_q    <= result_d;
            beat_q      <= beat_d;
            last_beat_q <= last_beat_d;
            acc_q       <= acc_d;
            seen_q      <= seen_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_rd_o     = ctrl_q.rd;
    assign rsp_result_o = result_q;
    assign rsp_error_o  = err_q;
endmodule

// File: tb/tb_vpu_lane_engine.sv
// Scoreboard bench for vpu_lane_engine: a reference model predicts each response at accept time.

module tb_vpu_lane_engine;
    typedef logic [7:0][31:0] vec_t;
    typedef struct {
        logic [4:0] rd;
        vec_t       res;
        logic       err;
        int         exp_cyc;
    } exp_t;

    localparam longint SMAXL = 64'sd2147483647;
    localparam longint SMINL = -64'sd2147483647 - 64'sd1;

    logic         clk = 0, rst_i = 1;
    logic         req_valid_i = 0, req_sat_i = 0, rsp_ready_i = 1;
    logic [3:0]   req_op_i = 0, req_vl_i = 0;
    logic [4:0]   req_rd_i = 0;
    logic [7:0]   req_mask_i = 0;
    vec_t         req_op1_i = '0, req_op2_i = '0;
    logic         req_ready_o, rsp_valid_o, rsp_error_o, busy_o;
    logic [4:0]   rsp_rd_o;
    logic [255:0] rsp_result_o;

    int   n_chk = 0, n_err = 0, cyc = 0;
    exp_t q[$];
    exp_t mon_e;
    logic prev_vld = 0, prev_rdy = 0, rand_bp = 0;
    vec_t a1, a2;

    vpu_lane_engine dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_sat_i(req_sat_i), .req_vl_i(req_vl_i),
        .req_rd_i(req_rd_i), .req_mask_i(req_mask_i),
        .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rd_o(rsp_rd_o), .rsp_result_o(rsp_result_o),
        .rsp_error_o(rsp_error_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rand_bp) begin #1; rsp_ready_i = 1'($urandom_range(0, 1)); end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic sat, input logic [3:0] vl,
                                  input logic [7:0] mask, input vec_t a, input vec_t b,
                                  output vec_t r, output logic err, output int lat);
        longint     s;
        logic [31:0] acc;
        bit         seen;
        r = '0; err = 0; lat = 1;
        if (op > 7 || vl > 8) begin err = 1; return; end
        if (vl == 0) return;
        lat = (int'(vl) + 3) / 4 + 1;
        if (op >= 5) begin
            acc = 0; seen = 0;
            for (int i = 0; i < int'(vl); i++) if (mask[i]) begin
                if (op == 5) acc = acc + a[i];
                else if (!seen || (op == 6 && $signed(a[i]) < $signed(acc))
                               || (op == 7 && $signed(a[i]) > $signed(acc))) acc = a[i];
                seen = 1;
            end
            r[0] = acc;
            return;
        end
        for (int i = 0; i < int'(vl); i++) begin
            if (!mask[i]) r[i] = a[i];
            else case (op)
                0, 1: begin
                    s = (op == 0) ? longint'($signed(a[i])) + longint'($signed(b[i]))
                                  : longint'($signed(a[i])) - longint'($signed(b[i]));
                    if (sat && s > SMAXL) s = SMAXL;
                    if (sat && s < SMINL) s = SMINL;
                    r[i] = s[31:0];
                end
                2: r[i] = a[i] * b[i];
                3: r[i] = ($signed(a[i]) < $signed(b[i])) ? a[i] : b[i];
                default: r[i] = ($signed(a[i]) > $signed(b[i])) ? a[i] : b[i];
            endcase
        end
    endfunction

    // Drive a request, push its prediction on the accept cycle, then scramble the bus.
    task automatic send(input logic [3:0] op, input logic sat, input logic [3:0] vl, input logic [4:0] rd,
                        input logic [7:0] mask, input vec_t a, input vec_t b);
        exp_t e;
        int   lat, n;
        model(op, sat, vl, mask, a, b, e.res, e.err, lat);
        e.rd = rd;
        req_op_i = op; req_sat_i = sat; req_vl_i = vl; req_rd_i = rd;
        req_mask_i = mask; req_op1_i = a; req_op2_i = b; req_valid_i = 1;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
        chk("accept_ready", req_ready_o, 1);
        e.exp_cyc = cyc + lat;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid_i = 0;
        req_op_i = 4'($urandom); req_vl_i = 4'($urandom); req_rd_i = 5'($urandom);
        req_mask_i = 8'($urandom); req_op1_i = {8{$urandom}}; req_op2_i = {8{$urandom}};
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (rsp_valid_o && !prev_vld) begin
                chk("rsp_q_depth", q.size(), 1);
                if (q.size() > 0) chk("latency", cyc, q[0].exp_cyc);
            end
            if (prev_vld && !prev_rdy) chk("vld_hold", rsp_valid_o, 1);
            if (rsp_valid_o && rsp_ready_i && q.size() > 0) begin
                mon_e = q.pop_front();
                chk("rd", rsp_rd_o, mon_e.rd);
                chk("result", rsp_result_o, mon_e.res);
                chk("error", rsp_error_o, mon_e.err);
            end
        end
        prev_vld = rsp_valid_o;
        prev_rdy = rsp_ready_i;
    end

    initial begin
        vec_t exp4;
        int   n;
        logic seen_v;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_result", rsp_result_o, 0);
        chk("rst_err_rd", {rsp_error_o, rsp_rd_o}, 0);
        @(posedge clk); #1;

        // Full-length ADD across both beats
        for (int i = 0; i < 8; i++) begin a1[i] = i; a2[i] = 10; end
        send(4'd0, 0, 4'd8, 5'd3, 8'hFF, a1, a2);
        wait_idle();

        // Saturating and wrapping ADD on a single element, garbage in the tail
        a1 = {8{32'hDEADBEEF}}; a2 = {8{32'h12345678}};
        a1[0] = 32'h7FFFFFF0; a2[0] = 32'h20;
        send(4'd0, 1, 4'd1, 5'd4, 8'hFF, a1, a2);
        send(4'd0, 0, 4'd1, 5'd5, 8'hFF, a1, a2);
        a1[0] = 32'h80000005; a2[0] = 32'h10;
        send(4'd1, 1, 4'd1, 5'd6, 8'h01, a1, a2);
        wait_idle();

        // REDMIN with masking, then no active element
        a1 = '0;
        a1[0] = -32'sd100; a1[1] = 3; a1[2] = -32'sd7; a1[3] = 9; a1[4] = 2; a1[5] = -32'sd500;
        send(4'd6, 0, 4'd5, 5'd7, 8'b0001_1110, a1, a2);
        send(4'd6, 0, 4'd5, 5'd8, 8'h00, a1, a2);
        send(4'd7, 0, 4'd6, 5'd9, 8'hFF, a1, a2);
        send(4'd5, 0, 4'd6, 5'd10, 8'b0010_1011, a1, a2);
        wait_idle();

        // Masked SUB held under backpressure
        for (int i = 0; i < 8; i++) begin a1[i] = 20; a2[i] = i; end
        exp4 = '0;
        exp4[0] = 20; exp4[1] = 20; exp4[2] = 18; exp4[3] = 20; exp4[4] = 16; exp4[5] = 15;
        rsp_ready_i = 0;
        send(4'd1, 0, 4'd6, 5'd11, 8'b0011_0101, a1, a2);
        n = 0;
        while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", rsp_valid_o, 1);
            chk("hold_result", rsp_result_o, exp4);
            chk("hold_req_ready", req_ready_o, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready_i = 1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_hs", req_ready_o, 1);
        wait_idle();

        // Direct-to-RESP cases
        send(4'hF, 0, 4'd4, 5'd12, 8'hFF, a1, a2);
        send(4'd0, 0, 4'd9, 5'd13, 8'hFF, a1, a2);
        send(4'd0, 0, 4'd0, 5'd14, 8'hFF, a1, a2);
        wait_idle();

        // Reset during the first EXEC beat drops the request
        for (int i = 0; i < 8; i++) begin a1[i] = $urandom; a2[i] = $urandom; end
        send(4'd2, 0, 4'd8, 5'd15, 8'hFF, a1, a2);
        chk("busy_in_exec", busy_o, 1);
        rst_i = 1;
        @(posedge clk); #1 rst_i = 0;
        q.delete();
        chk("rst_drop_valid", rsp_valid_o, 0);
        chk("rst_drop_ready", req_ready_o, 1);
        chk("rst_drop_busy", busy_o, 0);
        seen_v = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); seen_v = seen_v | rsp_valid_o; end
        chk("dropped_no_rsp", seen_v, 0);
        @(posedge clk); #1;

        // Random mix under random response backpressure
        rand_bp = 1;
        for (int t = 0; t < 40; t++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 9));
            if (op > 7) op = 4'($urandom_range(8, 15));
            for (int i = 0; i < 8; i++) begin
                a1[i] = (t % 2) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
                a2[i] = (t % 3 == 0) ? {1'b0, 31'h7FFFFFF0} + 32'($urandom_range(0, 15)) : $urandom;
            end
            send(op, 1'($urandom), 4'($urandom_range(0, 9)), 5'($urandom), 8'($urandom), a1, a2);
        end
        wait_idle();
        rand_bp = 0;
        #2 rsp_ready_i = 1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
